// File: rtl/sender_defs_pkg.sv
// Shared definitions for the serial frame sender: FSM encodings, line levels, defaults.
package sender_defs_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/sender_fifo.sv
// Synchronous byte FIFO for the frame sender; push ignored when full, pop ignored when empty.
module sender_fifo
    import sender_defs_pkg::*;
#(
    parameter int W     = DEF_DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clock_in,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/serial_frame_sender.sv
// Byte-serial framer (start, DATA_W bits LSB first, stop) paced by a sampled bit clock.
// Define SENDER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_frame_sender
    import sender_defs_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clock_in,
    input  logic              rst_n,
    input  logic              bit_clk_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(DATA_W);

    logic              s1, s2, s3;
    logic              tick;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              load;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
`ifdef SENDER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bit_clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    sender_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_in (clock_in),
        .rst_n    (rst_n),
        .push     (data_valid),
        .wr_data  (data_in),
        .pop      (fifo_pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign data_ready = !fifo_full;

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_q     <= LINE_IDLE;
            done_q   <= 1'b0;
`ifdef SENDER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef SENDER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // A new byte is taken from IDLE or straight out of STOP, so frames can run back to back.
    assign load = tick && !fifo_empty && (state_q == IDLE || state_q == STOP);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
`ifdef SENDER_PARITY_EN
        parity_d = parity_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: ;
                START: begin
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                    state_d = DATA;
                end
                DATA: begin
                    if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef SENDER_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = STOP_BIT;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
`ifdef SENDER_PARITY_EN
                PARITY: begin
                    tx_d    = STOP_BIT;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    done_d  = 1'b1;
                    tx_d    = LINE_IDLE;
                    state_d = IDLE;
                end
                default: begin
                    tx_d    = LINE_IDLE;
                    state_d = IDLE;
                end
            endcase
            if (load) begin
                fifo_pop = 1'b1;
                shift_d  = fifo_rd_data;
                tx_d     = START_BIT;
                state_d  = START;
`ifdef SENDER_PARITY_EN
                parity_d = ^fifo_rd_data;
`endif
            end
        end
    end

    assign tx_out     = tx_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Bench for serial_frame_sender: queue-based line model compared every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_serial_frame_sender;

    localparam int DEPTH = 4;
`ifdef SENDER_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clock_in = 1'b0;
    logic       rst_n = 1'b1;
    logic       bit_clk_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, tx_out, busy, frame_done;

    int errs = 0;
    int checks = 0;

    serial_frame_sender #(.FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
        .clock_in   (clock_in),
        .rst_n      (rst_n),
        .bit_clk_in (bit_clk_in),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #25 clock_in = ~clock_in;

    bit bc_run = 1'b0;
    int bc_half = 10;
    int bc_cnt = 0;
    initial begin
        forever begin
            @(posedge clock_in);
            if (bc_run) begin
                bc_cnt++;
                if (bc_cnt >= bc_half) begin
                    bc_cnt = 0;
                    #1 bit_clk_in = ~bit_clk_in;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: bits still to be sent for the current frame, plus a queue of waiting bytes.
    logic [7:0] m_fifo[$];
    logic       m_line[$];
    bit         m_in_frame = 0;
    bit         m_prev_bc = 0;
    int         m_dly = 0;
    bit         m_tick_now = 0;
    bit         m_pushed = 0;
    bit         m_ready_pre;
    logic       exp_tx = 1'b1, exp_done = 1'b0, exp_ready = 1'b1, exp_busy = 1'b0;

    always @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_line.delete();
            m_in_frame = 0;
            m_prev_bc  = 0;
            m_dly      = 0;
            m_tick_now = 0;
            m_pushed   = 0;
            exp_tx = 1'b1; exp_done = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0;
        end else begin
            m_ready_pre = (m_fifo.size() < DEPTH);
            m_tick_now = 0;
            m_pushed   = 0;
            exp_done   = 1'b0;
            if (m_dly > 0) begin
                m_dly--;
                if (m_dly == 0) m_tick_now = 1;
            end
            if (bit_clk_in && !m_prev_bc) m_dly = 2;
            m_prev_bc = bit_clk_in;
            if (m_tick_now) begin
                if (m_line.size() > 0) begin
                    exp_tx = m_line.pop_front();
                end else begin
                    if (m_in_frame) begin
                        exp_done = 1'b1;
                        m_in_frame = 0;
                        exp_tx = 1'b1;
                    end
                    if (m_fifo.size() > 0) begin
                        logic [7:0] b;
                        b = m_fifo.pop_front();
                        exp_tx = 1'b0;
                        for (int i = 0; i < 8; i++) m_line.push_back(b[i]);
`ifdef SENDER_PARITY_EN
                        m_line.push_back(^b);
`endif
                        m_line.push_back(1'b1);
                        m_in_frame = 1;
                    end
                end
            end
            if (data_valid && m_ready_pre) begin
                m_fifo.push_back(data_in);
                m_pushed = 1;
            end
            exp_ready = (m_fifo.size() < DEPTH);
            exp_busy  = m_in_frame || (m_fifo.size() > 0);
        end
    end

    bit   cmp_en = 0;
    logic rec_q[$];
    int   done_cnt = 0;
    always @(negedge clock_in) begin
        if (cmp_en) begin
            chk("tx_out", tx_out, exp_tx);
            chk("frame_done", frame_done, exp_done);
            chk("data_ready", data_ready, exp_ready);
            chk("busy", busy, exp_busy);
        end
        if (rst_n) begin
            if (m_tick_now && m_in_frame) rec_q.push_back(tx_out);
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        data_in = b;
        data_valid = 1'b1;
        do begin
            @(posedge clock_in);
            #1;
            n++;
        end while (!m_pushed && n < 4000);
        data_valid = 1'b0;
        data_in = 8'($urandom);
        chk("push_accepted", m_pushed, 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((m_in_frame || m_fifo.size() != 0 || m_dly != 0) && k < 20000) begin
            cyc(1);
            k++;
        end
        chk(name, k < 20000, 1);
        cyc(2);
    endtask

    task automatic wait_rec(input int n, input string name);
        int k;
        k = 0;
        while (rec_q.size() < n && k < 20000) begin
            cyc(1);
            k++;
        end
        chk(name, rec_q.size() >= n, 1);
    endtask

    function automatic logic [7:0] dec(input int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = rec_q[k*FL + 1 + i];
        return v;
    endfunction

    task automatic stall_low();
        if (bit_clk_in) @(negedge bit_clk_in);
        bc_run = 1'b0;
        cyc(4);
    endtask

    initial begin
        #(60000 * 50);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FL-1:0] a5_seq;
        logic [7:0]    burst[5];
        logic [7:0]    sent[$];
        logic          held;
        bit            stable;
        int            n;

`ifdef SENDER_PARITY_EN
        a5_seq = 11'b10101001010;
`else
        a5_seq = 10'b1101001010;
`endif
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h3C; burst[3] = 8'h81; burst[4] = 8'h5A;

        #5 rst_n = 1'b0;
        cyc(1);
        cmp_en = 1;
        cyc(2);
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ready", data_ready, 1);
        rst_n = 1'b1;
        cyc(2);

        // single byte 0xA5
        bc_half = 10;
        bc_run = 1'b1;
        rec_q.delete(); done_cnt = 0;
        push_byte(8'hA5);
        wait_idle("a5_idle");
        chk("a5_ticks", rec_q.size(), FL);
        for (int i = 0; i < FL; i++) chk($sformatf("a5_bit%0d", i), rec_q[i], a5_seq[i]);
        chk("a5_pulses", done_cnt, 1);
        chk("a5_busy_after", busy, 0);
        chk("a5_tx_after", tx_out, 1);

        // four consecutive pushes fill the FIFO, then run back to back
        stall_low();
        rec_q.delete(); done_cnt = 0;
        for (int i = 0; i < 4; i++) push_byte(burst[i]);
        chk("burst_ready_low", data_ready, 0);
        bc_run = 1'b1;
        wait_idle("burst_idle");
        chk("burst_ticks", rec_q.size(), 4 * FL);
        chk("burst_pulses", done_cnt, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("burst_byte%0d", i), dec(i), burst[i]);

        // fifth byte held while full is taken after the first pop
        stall_low();
        rec_q.delete(); done_cnt = 0;
        for (int i = 0; i < 4; i++) push_byte(burst[i]);
        chk("full_ready_low", data_ready, 0);
        bc_run = 1'b1;
        push_byte(burst[4]);
        wait_idle("full_idle");
        chk("full_ticks", rec_q.size(), 5 * FL);
        chk("full_pulses", done_cnt, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("full_byte%0d", i), dec(i), burst[i]);

        // reset while data bit 4 of 0x55 is on the line
        rec_q.delete(); done_cnt = 0;
        push_byte(8'h55);
        wait_rec(6, "rst_reach_bit4");
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx_out, 1);
        chk("midrst_done", frame_done, 0);
        cyc(3);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", data_ready, 1);
        chk("midrst_pulses", done_cnt, 0);
        rst_n = 1'b1;
        cyc(3);
        rec_q.delete(); done_cnt = 0;
        push_byte(8'h0F);
        wait_idle("after_rst_idle");
        chk("after_rst_ticks", rec_q.size(), FL);
        chk("after_rst_byte", dec(0), 8'h0F);
        chk("after_rst_pulses", done_cnt, 1);

        // bit clock stopped low mid-frame
        rec_q.delete(); done_cnt = 0;
        push_byte(8'hC3);
        wait_rec(4, "stall_reach");
        stall_low();
        held = tx_out;
        stable = 1;
        for (int i = 0; i < 2000; i++) begin
            cyc(1);
            if (tx_out !== held || busy !== 1'b1) stable = 0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_no_done", done_cnt, 0);
        bc_run = 1'b1;
        wait_idle("stall_idle");
        chk("stall_ticks", rec_q.size(), FL);
        chk("stall_byte", dec(0), 8'hC3);
        chk("stall_pulses", done_cnt, 1);

        // randomized bytes with random gaps
        rec_q.delete(); done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            sent.push_back(r);
            push_byte(r);
            cyc($urandom_range(0, 120));
        end
        wait_idle("rand_idle");
        chk("rand_ticks", rec_q.size(), 6 * FL);
        chk("rand_pulses", done_cnt, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rand_byte%0d", i), dec(i), sent[i]);

        // latency at a 500-cycle bit period: rise to tx change, counting the rise cycle as 1
        bc_half = 250;
        rec_q.delete(); done_cnt = 0;
        @(negedge bit_clk_in);
        push_byte(8'h96);
        @(posedge bit_clk_in);
        n = 0;
        do begin
            @(negedge clock_in);
            n++;
        end while (tx_out !== 1'b0 && n < 10);
        chk("latency_cycles", n, 4);
        #1;
        wait_idle("slow_idle");
        chk("slow_byte", dec(0), 8'h96);
        chk("slow_pulses", done_cnt, 1);

        bc_run = 1'b0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_sender.md
Name: serial_frame_sender

Overview:
- Byte-serial transmitter downstream of the 40 kHz bit-clock divider in the Sender design.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Frames each byte as start bit, 8 data bits LSB first, and stop bit; each bit lasts one bit_clk_in period.
- Runs entirely in the 20 MHz clock_in domain; bit_clk_in is sampled and edge-detected, never used as a clock.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; must be a power of 2, at least 2.
- DATA_W, 8, data bits per frame.

Ports:
- clock_in  input  1  system clock, 20 MHz
- rst_n  input  1  asynchronous active-low reset
- bit_clk_in  input  1  divided bit clock (40 kHz, 50% duty) from the divider stage
- data_in  input  DATA_W  byte to send
- data_valid  input  1  data_in valid this cycle
- data_ready  output  1  FIFO can accept; push = data_valid && data_ready
- tx_out  output  1  serial line, idle high
- busy  output  1  frame in progress or FIFO non-empty
- frame_done  output  1  one-cycle pulse at end of each stop bit

Behaviour:
- Reset (async assert, sync release), all flops cleared:
  - tx_out=1, busy=0, frame_done=0, data_ready=1.
  - FIFO empty, FSM in IDLE, synchronizer flops 0.
- Tick generation:
  - 2-flop synchronizer (s1, s2), then edge register s3; tick = s2 & ~s3.
  - Tick is a one-cycle pulse 3 clock_in cycles after the bit_clk_in rising edge.
- FIFO:
  - data_ready = !full.
  - A push while full is impossible because ready is low.
  - Push and pop in the same cycle are both honoured when neither empty nor full.
  - Push into an empty FIFO is not visible to a pop until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, PARITY (only with the feature), STOP. Transitions occur only on tick.
  - IDLE: tx_out=1. On tick with FIFO non-empty: pop into the shift register, tx_out<=0, go to START.
  - START: on tick, tx_out<=shift[0], bit_cnt<=0, go to DATA.
  - DATA: on tick, if bit_cnt==DATA_W-1, go to STOP (tx_out<=1), or to PARITY when enabled. Otherwise shift right, tx_out<=next bit, bit_cnt++.
  - STOP: on tick, pulse frame_done. If the FIFO is non-empty, pop and go to START with tx_out<=0 (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame length: exactly 10 ticks, or 11 with parity.
- tx_out is registered and glitch-free.
- Input stability: data_in is captured at push; later changes have no effect.
- busy = (state != IDLE) || !empty.
- Reset asserted mid-frame: tx_out goes to 1 immediately, the frame is aborted, the FIFO is flushed, and no frame_done pulse is produced.
- bit_clk_in stopped: the FSM holds its state and tx_out holds its value indefinitely.

Optional Feature:
- Macro: SENDER_PARITY_EN.
- Defined: the PARITY state is inserted after DATA.
  - tx_out = even parity (XOR of the DATA_W bits, latched at pop).
  - On tick, go to STOP with tx_out<=1. Frame is 11 ticks.
- Undefined: no PARITY state or logic; DATA goes directly to STOP; frame is 10 ticks.

Decomposition:
- Shared package/header sender_defs:
  - FSM state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit.
  - Line levels: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - Default DATA_W and FIFO_DEPTH.
- One sub-module: sender_fifo (synchronous FIFO with push/pop/full/empty/rd_data, async active-low reset), instantiated once.

Test Plan (bench drives bit_clk_in with a 20-cycle period to shorten runs; one run at 500 cycles checks real timing):
- Single byte 0xA5 pushed in IDLE -> tx_out per tick: 0,1,0,1,0,0,1,0,1,1. frame_done pulses once, then busy=0 and tx_out=1. With SENDER_PARITY_EN, a 0 parity bit precedes the stop bit.
- Push 0x00, 0xFF, 0x3C, 0x81 in consecutive cycles -> data_ready falls after the 4th push. Frames are back-to-back with no idle tick: 40 ticks total, 4 frame_done pulses.
- Push a 5th byte while full (valid held) -> not accepted until the first pop. It is then accepted and sent 5th, and no byte is lost or duplicated.
- rst_n low during DATA bit 4 of 0x55 -> tx_out=1 in the same cycle, no frame_done, FIFO empty. After release, the next pushed 0x0F is transmitted correctly.
- bit_clk_in held low for 2000 cycles mid-frame -> tx_out constant, state unchanged. On resume, the frame completes with the correct remaining bits.
- Tick latency: bit_clk_in rising edge -> tx_out changes exactly 4 clock_in cycles later (3 to tick + 1 register); checked at a 500-cycle period.
